data_sram_resp: RTL
===================

# data_sram_resp

Data-side memory responder for the five-stage pipeline: it answers the `data_sram_*` requests that EX drives and returns `data_sram_rdata`, which MEM consumes one cycle later. It holds a word-organised SRAM array with byte-lane writes, a registered read port, and optional wait states. When wait states are enabled, it asserts `stallreq` to CTRL so the pipeline holds the request stable until the access completes.

## Interface
- `ADDR_WIDTH`, 12: word-index width; the array holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 0: stall cycles inserted per access, range 0..15.
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `data_sram_en`  in  1  request valid.
- `data_sram_wen`  in  4  byte-lane write enables; 4'b0000 means read.
- `data_sram_addr`  in  32  byte address.
- `data_sram_wdata`  in  32  write data, lane i = bits 8i+7:8i.
- `data_sram_rdata`  out  32  registered read data.
- `stallreq`  out  1  combinational stall request to CTRL.

## Operation
- Word index = `data_sram_addr[ADDR_WIDTH+1:2]`.
  - Bits 1:0 are ignored.
  - Upper bits are ignored, so addresses alias modulo the array size.
- An access is performed at one rising edge, called the completion edge:
  - Write: each lane with `wen[i]`=1 takes `wdata` lane i; the other lanes keep their value. `rdata` holds.
  - Read: `rdata` <= the array word.
  - `rdata` changes only on a completed read.
- States: IDLE, WAIT. There is a 4-bit down-counter `cnt`.
- IDLE, `en`=0: no access; `stallreq`=0.
- IDLE, `en`=1, WAIT_CYCLES=0: this edge is the completion edge; stay in IDLE; `stallreq`=0.
- IDLE, `en`=1, WAIT_CYCLES=N>0: `stallreq`=1 this cycle; next state WAIT; `cnt` <= N-1; no access.
- WAIT, `en`=1, `cnt`!=0: `stallreq`=1; `cnt` decrements.
- WAIT, `en`=1, `cnt`=0: `stallreq`=0; this edge is the completion edge, using the current inputs; return to IDLE.
- WAIT, `en`=0 (request withdrawn by flush): `stallreq`=0; abort with no array or `rdata` change; return to IDLE.
- `stallreq` = (IDLE & `en` & WAIT_CYCLES!=0) | (WAIT & `en` & `cnt`!=0).
- Reset (`resetn`=0 at an edge):
  - state IDLE, `cnt`=0, `data_sram_rdata`=32'h0, `stallreq`=0.
  - Any in-flight access is aborted without writing.
  - Array contents are not reset.

## Timing
- Read latency: the address is presented in cycle k; data is valid in cycle k+1+WAIT_CYCLES. MEM samples it in the cycle after the request leaves EX.
- Per access, `stallreq` is high for exactly WAIT_CYCLES consecutive cycles, starting in the cycle the request first appears.
- Back-to-back requests:
  - With WAIT_CYCLES=0, one access completes per cycle.
  - Otherwise, the next request is evaluated in IDLE in the cycle after the completion edge.
- Write then read of the same word on consecutive completion edges: the read returns the newly written merged word. The array is write-first across edges; there is no same-edge hazard because only one access completes per edge.
- `en`=1 with `wen` changing mid-WAIT: only the values present at the completion edge are used.
- `resetn` low during WAIT: the next cycle is IDLE with `stallreq`=0, even if `en` is still high. Once IDLE, a still-high `en` starts a fresh access.

## Test plan
- Reset: hold `resetn`=0 for 2 cycles with `en`=1 -> `rdata`=0, `stallreq`=0, no write occurs (a subsequent read of that word returns the value written before reset).
- WAIT_CYCLES=0:
  - Write 32'hDEADBEEF, `wen`=4'hF, to address 0x10.
  - Next cycle, read 0x10 -> `rdata`=32'hDEADBEEF one cycle after the read; `stallreq` never high.
- Byte lanes:
  - Write 32'h11223344, `wen`=4'hF, to address 0x20.
  - Then write 32'hAABBCCDD, `wen`=4'b0101, to address 0x22.
  - Then read 0x20 -> 32'h11BB33DD, confirming bits 1:0 are ignored.
- WAIT_CYCLES=3, read with `en` held -> `stallreq` high for exactly 3 cycles; `rdata` updates at the edge after `stallreq` falls; `cnt` sequence 2,1,0.
- WAIT_CYCLES=3, write request with `en` dropped after 1 stall cycle -> `stallreq` falls immediately; a subsequent read shows the old contents.
- Aliasing: with ADDR_WIDTH=12, write to 0x0000_4004 then read 0x0000_0004 -> same data returned.

Source files
------------

// File: rtl/data_sram_resp.sv
// data_sram_resp: word-organised data SRAM with byte-lane writes, registered read port and optional wait states.
module data_sram_resp #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);
    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic done, stall;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0] mem [2**ADDR_WIDTH];
    logic unused;
    assign idx    = data_sram_addr[ADDR_WIDTH+1:2];
    assign unused = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        done      = 1'b0;
        if (state == S_IDLE) begin
            if (data_sram_en && WC == 4'd0) begin
                done = 1'b1;
            end else if (data_sram_en) begin
                stall     = 1'b1;
                state_nxt = S_WAIT;
                cnt_nxt   = WC - 4'd1;
            end
        end else if (!data_sram_en) begin
            state_nxt = S_IDLE;
        end else if (cnt != 4'd0) begin
            stall   = 1'b1;
            cnt_nxt = cnt - 4'd1;
        end else begin
            done      = 1'b1;
            state_nxt = S_IDLE;
        end
    end
    // reset masks both the stall and the access so nothing in flight can commit
    assign stallreq = stall & resetn;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= S_IDLE;
            cnt             <= 4'd0;
            data_sram_rdata <= 32'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (done && data_sram_wen == 4'b0000) data_sram_rdata <= mem[idx];
        end
    end
    always_ff @(posedge clk) begin
        if (done && resetn)
            for (int i = 0; i < 4; i++)
                if (data_sram_wen[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
    end
endmodule
